// File: rtl/picomips_pkg.sv
// rtl/picomips_pkg.sv - shared constants and types for the picoMips register store arbiter
package picomips_pkg;

  localparam int DW = 8;
  localparam int AW = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } fsm_state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - two-way round-robin select producing a one-hot grant
module rr_pick (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic [1:0] eff;

  assign eff = req_i & mask_i;

  // A lone eligible request wins outright; the pointer only breaks ties.
  always_comb begin
    gnt_o = eff;
    if (eff == 2'b11) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter with lock and read-response stage for the register store
module regfile_arbiter
  import picomips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  input  logic          lock0_i,
  input  logic          lock1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] addr_o,
  output logic          write_o,
  output logic [DW-1:0] wdata_o,
  input  logic [DW-1:0] data_i
);

  fsm_state_t state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       pend_q, pend_d;
  req_idx_t   pend_idx_q, pend_idx_d;
  logic [1:0] mask;
  logic [1:0] pick;

  always_comb begin
    mask = 2'b11;
    case (state_q)
      OWN0:    mask = 2'b01;
      OWN1:    mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  rr_pick u_rr_pick (
    .req_i  ({req1_i, req0_i}),
    .ptr_i  (ptr_q),
    .mask_i (mask),
    .gnt_o  (pick)
  );

  // Grants are combinational, so reset must gate them directly.
  assign gnt0_o = pick[0] & ~rst;
  assign gnt1_o = pick[1] & ~rst;

  always_comb begin
    addr_o  = '0;
    write_o = 1'b0;
    wdata_o = '0;
    if (gnt0_o) begin
      addr_o  = addr0_i;
      write_o = we0_i;
      wdata_o = wdata0_i;
    end else if (gnt1_o) begin
      addr_o  = addr1_i;
      write_o = we1_i;
      wdata_o = wdata1_i;
    end
  end

  // With lock low in OWNn either no request remains or the grant is the
  // final unlocked access, so lock alone decides the exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt0_o && lock0_i)      state_d = OWN0;
        else if (gnt1_o && lock1_i) state_d = OWN1;
      end
      OWN0:    if (!lock0_i) state_d = IDLE;
      OWN1:    if (!lock1_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt0_o)      ptr_d = 1'b1;
    else if (gnt1_o) ptr_d = 1'b0;
  end

  assign pend_d     = (gnt0_o || gnt1_o) && !write_o;
  assign pend_idx_d = gnt1_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  assign rvalid0_o = pend_q && (pend_idx_q == 1'b0);
  assign rvalid1_o = pend_q && (pend_idx_q == 1'b1);
  assign rdata_o   = pend_q ? data_i : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed self-checking bench for regfile_arbiter with a register store model
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic       addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, write;
  logic       addr;
  logic [7:0] rdata, wdata, data;
  logic [7:0] mem [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (req0),
    .req1_i    (req1),
    .we0_i     (we0),
    .we1_i     (we1),
    .addr0_i   (addr0),
    .addr1_i   (addr1),
    .wdata0_i  (wdata0),
    .wdata1_i  (wdata1),
    .lock0_i   (lock0),
    .lock1_i   (lock1),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .rvalid0_o (rvalid0),
    .rvalid1_o (rvalid1),
    .rdata_o   (rdata),
    .addr_o    (addr),
    .write_o   (write),
    .wdata_o   (wdata),
    .data_i    (data)
  );

  // Register store: registered read of the pre-write value, write at the issue edge.
  always @(posedge clk) begin
    data <= mem[addr];
    if (write) mem[addr] <= wdata;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Step to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {gnt0, gnt1, rvalid0, rvalid1, write, addr, rdata, wdata}
  function automatic logic [31:0] outs();
    return {11'b0, gnt0, gnt1, rvalid0, rvalid1, write, addr, rdata, wdata};
  endfunction

  function automatic logic [31:0] exp_o(input logic g0, input logic g1, input logic r0,
                                        input logic r1, input logic w, input logic a,
                                        input logic [7:0] rd, input logic [7:0] wd);
    return {11'b0, g0, g1, r0, r1, w, a, rd, wd};
  endfunction

  initial begin
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    rst = 1'b1;
    {req0, req1, we0, we1, lock0, lock1, addr0, addr1} = '0;
    wdata0 = '0;
    wdata1 = '0;

    // Reset with a request pending: no grant may issue.
    req0 = 1'b1;
    #2;
    chk("reset_outputs", outs(), '0);
    tick();
    req0 = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1 chk($sformatf("idle_%0d", i), outs(), '0);
    end

    // Write by requester 0, then read of the same address by requester 1.
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 1'b1; wdata0 = 8'h5A;
    #1 chk("wr0_issue", outs(), exp_o(1, 0, 0, 0, 1, 1, 8'h00, 8'h5A));
    tick();
    req0 = 1'b0; we0 = 1'b0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 1'b1;
    #1 chk("rd1_issue", outs(), exp_o(0, 1, 0, 0, 0, 1, 8'h00, 8'h00));
    tick();
    req1 = 1'b0;
    #1 chk("rd1_resp", outs(), exp_o(0, 0, 0, 1, 0, 0, 8'h5A, 8'h00));

    // Both requesters reading continuously: strict alternation.
    tick();
    req0 = 1'b1; addr0 = 1'b0;
    req1 = 1'b1; addr1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("alt_%0d", k), outs(),
             exp_o(k % 2 == 0, k % 2 == 1,
                   k > 0 && (k - 1) % 2 == 0, k > 0 && (k - 1) % 2 == 1,
                   0, (k % 2 == 1),
                   (k == 0) ? 8'h00 : (((k - 1) % 2 == 0) ? 8'h11 : 8'h5A), 8'h00));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #1 chk("alt_tail", outs(), exp_o(0, 0, 0, 1, 0, 0, 8'h5A, 8'h00));

    // Locked read-modify-write by requester 1 while requester 0 waits.
    tick();
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 1'b0;
    #1 chk("lock_rd", outs(), exp_o(0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 1'b1;
    we1 = 1'b1; wdata1 = 8'hFF;
    #1 chk("lock_wr", outs(), exp_o(0, 1, 0, 1, 1, 0, 8'h11, 8'hFF));
    tick();
    req1 = 1'b0; we1 = 1'b0; wdata1 = '0;
    #1 chk("lock_hold", outs(), exp_o(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    lock1 = 1'b0;
    #1 chk("lock_release", outs(), exp_o(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    #1 chk("post_lock_gnt0", outs(), exp_o(1, 0, 0, 0, 0, 1, 8'h00, 8'h00));
    tick();
    req0 = 1'b0;
    #1 chk("post_lock_rd0", outs(), exp_o(0, 0, 1, 0, 0, 0, 8'h5A, 8'h00));

    // Reset in the response cycle suppresses RValid and restores pointer 0.
    tick();
    req0 = 1'b1; addr0 = 1'b0;
    #1 chk("rst_rd_issue", outs(), exp_o(1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    req0 = 1'b0;
    rst = 1'b1;
    #1 chk("rst_rvalid", outs(), '0);
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr1 = 1'b1;
    #1 chk("rst_ptr0", outs(), exp_o(1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    req0 = 1'b0; req1 = 1'b0;
    #1 chk("rst_store_kept", outs(), exp_o(0, 0, 1, 0, 0, 0, 8'hFF, 8'h00));

    // Write then read of the same address on consecutive cycles.
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 1'b0; wdata0 = 8'h80;
    #1 chk("raw_wr", outs(), exp_o(1, 0, 0, 0, 1, 0, 8'h00, 8'h80));
    tick();
    we0 = 1'b0; wdata0 = '0;
    #1 chk("raw_rd", outs(), exp_o(1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tick();
    req0 = 1'b0;
    #1 chk("raw_resp", outs(), exp_o(0, 0, 1, 0, 0, 0, 8'h80, 8'h00));

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
